packer_input_arbiter: RTL and testbench

//  Round-robin arbiter that shares one DataPacker input port between NUM_REQ trace requesters.
//  A grant is frame-atomic: the owner keeps the packer until it sends an eof beat, so the

---
 rtl/packer_input_arbiter.sv | 135 +++++++++++++
 tb/tb_packer_input_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/packer_input_arbiter.sv
// Frame-atomic round-robin arbiter in front of the DataPacker input port.
// Adds an owner-stall watchdog and a completed-frame counter.
module packer_input_arbiter #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_CHAINS = 4,
    parameter int TIMEOUT    = 64,
    localparam int CHAIN_W   = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1,
    localparam int VW        = N * DATA_WIDTH,
    localparam int OW        = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tracing,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_eof,
    input  logic [NUM_REQ*CHAIN_W-1:0] req_chainId,
    input  logic [NUM_REQ*VW-1:0]      req_vector,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       valid_out,
    output logic                       eof_out,
    output logic [CHAIN_W-1:0]         chainId_out,
    output logic [VW-1:0]              vector_out,
    output logic [OW-1:0]              owner,
    output logic                       timeout_err,
    output logic [15:0]                frame_count
);
    localparam int IW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state, state_nxt;
    logic [OW-1:0] rr_ptr;
    logic [OW-1:0] winner;
    logic          win_found;
    logic [IW-1:0] idle_cnt;
    logic          accept;
    logic          stall;
    logic          expire;
    logic          owner_eof;
    logic          grant;

    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return OW'(s);
    endfunction

    // first valid requester scanning forward from rr_ptr
    always_comb begin
        winner    = rr_ptr;
        win_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_valid[wrap_inc(rr_ptr, i)]) begin
                winner    = wrap_inc(rr_ptr, i);
                win_found = 1'b1;
            end
        end
    end

    assign grant     = (state == IDLE) && tracing && win_found;
    assign accept    = (state == OWN) && tracing && req_valid[owner];
    assign stall     = (state == OWN) && tracing && !req_valid[owner];
    assign expire    = stall && (idle_cnt == IW'(TIMEOUT - 1));
    assign owner_eof = req_eof[owner];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (grant) state_nxt = OWN;
            OWN:  if ((accept && owner_eof) || expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == OWN) req_ready[owner] = tracing;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner       <= '0;
            rr_ptr      <= '0;
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
            frame_count <= '0;
        end else begin
            if (grant) begin
                owner    <= winner;
                idle_cnt <= '0;
            end
            if (accept) begin
                idle_cnt <= '0;
                if (owner_eof) begin
                    frame_count <= frame_count + 16'd1;
                    rr_ptr      <= wrap_inc(owner, 1);
                end
            end else if (stall) begin
                if (expire) begin
                    timeout_err <= 1'b1;
                    rr_ptr      <= wrap_inc(owner, 1);
                    idle_cnt    <= '0;
                end else begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end
        end
    end

    // data outputs hold their last beat when nothing is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out   <= 1'b0;
            eof_out     <= 1'b0;
            chainId_out <= '0;
            vector_out  <= '0;
        end else begin
            valid_out <= accept;
            if (accept) begin
                eof_out     <= owner_eof;
                chainId_out <= req_chainId[int'(owner)*CHAIN_W +: CHAIN_W];
                vector_out  <= req_vector[int'(owner)*VW +: VW];
            end
        end
    end

endmodule

// File: tb/tb_packer_input_arbiter.sv
// Randomised and directed checks of packer_input_arbiter
// against a cycle-level behavioural model.
module tb_packer_input_arbiter;
    localparam int N       = 8;
    localparam int DW      = 32;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 64;
    localparam int CW      = 2;
    localparam int VW      = N * DW;
    localparam int OW      = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    tracing;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_eof;
    logic [NUM_REQ*CW-1:0]   req_chainId;
    logic [NUM_REQ*VW-1:0]   req_vector;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    valid_out;
    logic                    eof_out;
    logic [CW-1:0]           chainId_out;
    logic [VW-1:0]           vector_out;
    logic [OW-1:0]           owner;
    logic                    timeout_err;
    logic [15:0]             frame_count;

    packer_input_arbiter #(
        .N(N), .DATA_WIDTH(DW), .NUM_REQ(NUM_REQ),
        .MAX_CHAINS(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .tracing(tracing),
        .req_valid(req_valid), .req_eof(req_eof),
        .req_chainId(req_chainId), .req_vector(req_vector),
        .req_ready(req_ready), .valid_out(valid_out),
        .eof_out(eof_out), .chainId_out(chainId_out),
        .vector_out(vector_out), .owner(owner),
        .timeout_err(timeout_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    logic          src_valid [NUM_REQ];
    logic          src_eof   [NUM_REQ];
    logic [CW-1:0] src_cid   [NUM_REQ];
    logic [VW-1:0] src_vec   [NUM_REQ];

    always_comb begin
        req_valid   = '0;
        req_eof     = '0;
        req_chainId = '0;
        req_vector  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_valid[r]            = src_valid[r];
            req_eof[r]              = src_eof[r];
            req_chainId[r*CW +: CW] = src_cid[r];
            req_vector[r*VW +: VW]  = src_vec[r];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // behavioural model state
    bit          m_own;
    int          m_owner, m_rr, m_idle, m_frames;
    bit          m_terr, m_vo, m_eof;
    int          m_cid;
    logic [VW-1:0] m_vec;
    logic [NUM_REQ-1:0] acc_mask;

    // stimulus controls
    logic [NUM_REQ-1:0] gen_en;
    int gen_pct, eof_pct, gap;
    bit rand_trace;

    task automatic model_init();
        m_own = 0; m_owner = 0; m_rr = 0; m_idle = 0; m_frames = 0;
        m_terr = 0; m_vo = 0; m_eof = 0; m_cid = 0; m_vec = '0;
    endtask

    task automatic model_step();
        bit acc;
        int w;
        acc  = m_own && tracing && src_valid[m_owner];
        m_vo = acc;
        if (acc) begin
            m_eof = src_eof[m_owner];
            m_cid = int'(src_cid[m_owner]);
            m_vec = src_vec[m_owner];
        end
        if (tracing) begin
            if (!m_own) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    w = (m_rr + k) % NUM_REQ;
                    if (!m_own && src_valid[w]) begin
                        m_own = 1; m_owner = w; m_idle = 0;
                    end
                end
            end else if (acc) begin
                m_idle = 0;
                if (m_eof) begin
                    m_frames = (m_frames + 1) % 65536;
                    m_rr     = (m_owner + 1) % NUM_REQ;
                    m_own    = 0;
                end
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_terr = 1;
                    m_rr   = (m_owner + 1) % NUM_REQ;
                    m_own  = 0;
                end
            end
        end
    endtask

    task automatic set_beat(input int r, input bit e);
        src_valid[r] = 1'b1;
        src_eof[r]   = e;
        src_cid[r]   = CW'($urandom_range(0, 3));
        for (int k = 0; k < N; k++) src_vec[r][k*DW +: DW] = $urandom();
    endtask

    task automatic clear_src();
        for (int r = 0; r < NUM_REQ; r++) begin
            src_valid[r] = 0; src_eof[r] = 0;
            src_cid[r] = '0; src_vec[r] = '0;
        end
    endtask

    task automatic gen_step();
        for (int r = 0; r < NUM_REQ; r++) begin
            if (acc_mask[r]) src_valid[r] = 1'b0;
            if (!src_valid[r] && gen_en[r] && $urandom_range(0, 99) < gen_pct)
                set_beat(r, $urandom_range(0, 99) < eof_pct);
        end
        if (rand_trace) begin
            if (gap > 0) begin
                tracing = 1'b0;
                gap--;
            end else begin
                tracing = 1'b1;
                if ($urandom_range(0, 29) == 0) gap = 5;
            end
        end
    endtask

    // called at a negedge, returns at the next negedge
    task automatic cycle();
        logic [NUM_REQ-1:0] exp_rdy;
        exp_rdy = '0;
        if (m_own && tracing) exp_rdy[m_owner] = 1'b1;
        #1;
        check("req_ready", req_ready, exp_rdy);
        @(posedge clk);
        acc_mask = exp_rdy & req_valid;
        model_step();
        #1;
        check("valid_out", valid_out, m_vo);
        check("eof_out", eof_out, m_eof);
        check("chainId_out", chainId_out, m_cid);
        check("vector_out", vector_out, m_vec);
        check("owner", owner, m_owner);
        check("timeout_err", timeout_err, m_terr);
        check("frame_count", frame_count, m_frames);
        @(negedge clk);
        gen_step();
    endtask

    task automatic wait_accept(input int r);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!acc_mask[r] && n < 100);
        if (!acc_mask[r]) check("accept_wait", 0, 1);
    endtask

    // asserts reset between clock edges; returns at a negedge with reset low
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_vector", vector_out, 0);
        check("rst_eof_cid", {eof_out, chainId_out}, 0);
        check("rst_owner", owner, 0);
        check("rst_terr_fc", {timeout_err, frame_count}, 0);
        model_init();
        clear_src();
        acc_mask = '0;
        gen_en = '0;
        gap = 0;
        rand_trace = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; tracing = 1'b0;
        clear_src(); model_init();
        acc_mask = '0; gen_en = '0;
        gen_pct = 0; eof_pct = 0; gap = 0; rand_trace = 0;
        @(negedge clk);
        do_reset();

        // single requester, 3-beat frame
        tracing = 1'b1;
        for (int b = 0; b < 3; b++) begin
            set_beat(0, b == 2);
            wait_accept(0);
        end
        check("s1_eof_out", eof_out, 1);
        check("s1_frames", frame_count, 1);

        // all requesters, continuous single-beat frames
        do_reset();
        tracing = 1'b1;
        gen_en = '1; gen_pct = 100; eof_pct = 100;
        for (int r = 0; r < NUM_REQ; r++) set_beat(r, 1'b1);
        repeat (10) cycle();
        check("s2_frames", frame_count, 5);
        check("s2_owner", owner, 0);

        // owner holds grant while another requester waits
        do_reset();
        tracing = 1'b1;
        set_beat(1, 1'b0);
        wait_accept(1);
        set_beat(2, 1'b1);
        set_beat(1, 1'b0);
        wait_accept(1);
        set_beat(1, 1'b1);
        wait_accept(1);
        wait_accept(2);
        check("s3_owner", owner, 2);

        // owner stalls mid-frame, watchdog releases it
        do_reset();
        tracing = 1'b1;
        set_beat(2, 1'b0);
        wait_accept(2);
        set_beat(3, 1'b1);
        repeat (70) cycle();
        check("s4_terr", timeout_err, 1);
        check("s4_owner", owner, 3);
        check("s4_frames", frame_count, 1);

        // random traffic with tracing gaps and an async reset mid-run
        do_reset();
        tracing = 1'b1;
        gen_en = '1; gen_pct = 60; eof_pct = 30; rand_trace = 1;
        repeat (400) cycle();
        do_reset();
        tracing = 1'b1;
        gen_en = '1; gen_pct = 50; eof_pct = 40; rand_trace = 1;
        repeat (400) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
